// File: rtl/alu_iter.sv
// alu_iter: handshaked execute ALU with iterative multiply/divide.
// Define ALU_ITER_FAST_MUL_EN for a single-cycle combinational multiplier.
module alu_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      func_control,
  input  logic [3:0]      inner_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, m, nhi, nlo, ma, mb, single, fin, dv, sra_v, quo, rem;
  logic [3:0] op_fc, op_ic;
  logic neg, neg_in, accept, sa, sb, is_mul, is_div, div_sgn, div_zero, div_ovf, iter;
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic [SW-1:0] shamt;
  function automatic logic [XLEN-1:0] mul_sel(input logic n, input logic [2*XLEN-1:0] p,
                                              input logic [3:0] ic);
    logic [2*XLEN-1:0] s;
    s = n ? -p : p;
    return ic == 4'd0 ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction
  assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = state == DONE;
  // Operand decode: signedness picks magnitudes and the final sign fix for mul/div
  always_comb begin
    is_mul   = func_control == 4'd5 && inner_control < 4'd4;
    is_div   = func_control == 4'd3 && inner_control < 4'd4;
    div_sgn  = inner_control == 4'd0 || inner_control == 4'd2;
    sa       = is_mul ? (inner_control == 4'd1 || inner_control == 4'd2) : div_sgn;
    sb       = is_mul ? inner_control == 4'd1 : div_sgn;
    ma       = (sa && src1[XLEN-1]) ? -src1 : src1;
    mb       = (sb && src2[XLEN-1]) ? -src2 : src2;
    neg_in   = (is_div && inner_control[1]) ? (sa && src1[XLEN-1])
             : ((sa && src1[XLEN-1]) ^ (sb && src2[XLEN-1]));
    div_zero = src2 == '0;
    div_ovf  = div_sgn && src1 == MINV && src2 == '1;
    quo      = div_zero ? '1 : src1;
    rem      = div_zero ? src1 : '0;
`ifdef ALU_ITER_FAST_MUL_EN
    iter     = is_div && !div_zero && !div_ovf;
`else
    iter     = (is_div && !div_zero && !div_ovf) || is_mul;
`endif
    shamt    = src2[SW-1:0];
    sra_v    = XLEN'($signed(src1) >>> shamt);
  end
  always_comb begin
    single = '0;
    case (func_control)
      4'd0: single = inner_control == 4'd0 ? src1 + src2 : inner_control == 4'd1 ? src1 - src2 : '0;
      4'd1: single = inner_control == 4'd0 ? src1 << shamt : inner_control == 4'd1 ? src1 >> shamt
                   : inner_control == 4'd2 ? sra_v : '0;
      4'd2: single = inner_control == 4'd0 ? {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)}
                   : inner_control == 4'd1 ? {{(XLEN-1){1'b0}}, src1 < src2} : '0;
      4'd3: single = is_div ? (inner_control[1] ? rem : quo) : '0;
      4'd4: single = inner_control == 4'd0 ? src1 & src2 : inner_control == 4'd1 ? src1 | src2
                   : inner_control == 4'd2 ? src1 ^ src2 : '0;
`ifdef ALU_ITER_FAST_MUL_EN
      4'd5: single = is_mul ? mul_sel(neg_in, {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb}, inner_control) : '0;
`endif
      4'd6, 4'd7: single = src2;
      default: single = '0;
    endcase
  end
  // One iteration step; the final step also folds in the sign fix so the result lands with DONE
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, m};
    nhi      = op_fc == 4'd5 ? mul_sum[XLEN:1]
             : (div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0]);
    nlo      = op_fc == 4'd5 ? {mul_sum[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], ~div_diff[XLEN]};
    dv       = op_ic[1] ? nhi : nlo;
    fin      = op_fc == 4'd5 ? mul_sel(neg, {nhi, nlo}, op_ic) : (neg ? -dv : dv);
  end
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (accept) state_n = iter ? BUSY : DONE;
    else if (state == BUSY && cnt == CW'(1)) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      m          <= '0;
      op_fc      <= '0;
      op_ic      <= '0;
      neg        <= 1'b0;
      result_out <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op_fc <= func_control;
      op_ic <= inner_control;
      neg   <= neg_in;
      m     <= is_mul ? ma : mb;
      lo    <= is_mul ? mb : ma;
      hi    <= '0;
      cnt   <= iter ? CW'(XLEN) : '0;
      if (!iter) result_out <= single;
    end else if (state == BUSY) begin
      hi  <= nhi;
      lo  <= nlo;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) result_out <= fin;
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vectors into alu_iter; a monitor checks results against a scoreboard queue.
module tb_alu_iter;
  localparam int X = 64;
  localparam int DLAT = X + 1;
`ifdef ALU_ITER_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = X + 1;
`endif
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [X-1:0] src1 = '0, src2 = '0, result_out;
  logic [3:0] fc = '0, ic = '0;
  int tests = 0, fails = 0, lat;
  logic [X-1:0] q[$];
  string nq[$];
  localparam logic [X-1:0] ONES = '1;
  localparam logic [X-1:0] MINV = {1'b1, {(X-1){1'b0}}};

  always #5 clk = ~clk;

  alu_iter #(.XLEN(X)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .func_control(fc), .inner_control(ic),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out)
  );

  task automatic chk(input string n, input logic [X-1:0] act, input logic [X-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  initial begin : monitor
    logic [X-1:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %h want no output", result_out);
        end else begin
          e = q.pop_front();
          n = nq.pop_front();
          chk(n, result_out, e);
        end
      end
    end
  end

  // Drives from just after a rising edge, returns just after the accepting edge
  task automatic send(input string n, input logic [3:0] f, input logic [3:0] i,
                      input logic [X-1:0] a, input logic [X-1:0] b, input logic [X-1:0] e,
                      input bit push, input logic rdy);
    int k;
    @(posedge clk); #1;
    fc = f; ic = i; src1 = a; src2 = b; in_valid = 1; out_ready = rdy;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got in_ready 0 want 1", n);
      @(posedge clk); #1 in_valid = 0;
      return;
    end
    if (push) begin
      q.push_back(e);
      nq.push_back(n);
    end
    @(posedge clk); #1 in_valid = 0;
  endtask

  task automatic wait_out(input string n, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!out_valid && l < 200);
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no out_valid want out_valid", n);
    end
  endtask

  task automatic run(input string n, input logic [3:0] f, input logic [3:0] i,
                     input logic [X-1:0] a, input logic [X-1:0] b, input logic [X-1:0] e,
                     input int el);
    int l;
    send(n, f, i, a, b, e, 1, 1);
    wait_out(n, l);
    chk({n, "_lat"}, X'(l), X'(el));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", X'(out_valid), '0);
    chk("rst_result", result_out, '0);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", X'(in_ready), X'(1));
    // Result held with out_ready low, then released together with a new accept
    send("sub", 4'd0, 4'd1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd8, 1, 0);
    wait_out("sub", lat);
    chk("sub_lat", X'(lat), X'(1));
    send("add_b2b", 4'd0, 4'd0, 64'd1, 64'd1, 64'd2, 1, 1);
    wait_out("add_b2b", lat);
    chk("add_b2b_lat", X'(lat), X'(1));
    run("sll", 4'd1, 4'd0, 64'd1, 64'd63, MINV, 1);
    run("sra", 4'd1, 4'd2, MINV, 64'd4, 64'hF800_0000_0000_0000, 1);
    run("srl", 4'd1, 4'd1, MINV, 64'd4, 64'h0800_0000_0000_0000, 1);
    run("slt", 4'd2, 4'd0, ONES, 64'd5, 64'd1, 1);
    run("sltu", 4'd2, 4'd1, ONES, 64'd5, 64'd0, 1);
    run("xor", 4'd4, 4'd2, 64'hF0, 64'h3C, 64'hCC, 1);
    run("lui", 4'd7, 4'd0, 64'd9, 64'h1234_5000, 64'h1234_5000, 1);
    run("bad_fc", 4'd8, 4'd0, 64'd9, 64'd9, 64'd0, 1);
    run("bad_ic", 4'd0, 4'd5, 64'd9, 64'd9, 64'd0, 1);
    run("divu", 4'd3, 4'd1, 64'd100, 64'd7, 64'd14, DLAT);
    run("rem_neg", 4'd3, 4'd2, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, DLAT);
    run("div_neg", 4'd3, 4'd0, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, DLAT);
    run("div_zero", 4'd3, 4'd0, 64'd42, 64'd0, ONES, 1);
    run("remu_zero", 4'd3, 4'd3, 64'd42, 64'd0, 64'd42, 1);
    run("div_ovf", 4'd3, 4'd0, MINV, ONES, MINV, 1);
    run("rem_ovf", 4'd3, 4'd2, MINV, ONES, 64'd0, 1);
    run("mulhsu", 4'd5, 4'd2, ONES, 64'd2, ONES, MLAT);
    run("mulhu", 4'd5, 4'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, MLAT);
    run("mul_lo", 4'd5, 4'd0, -64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, MLAT);
    run("mulh", 4'd5, 4'd1, -64'd2, 64'd3, ONES, MLAT);
    // Stall in DONE for 10 cycles
    send("and_stall", 4'd4, 4'd0, 64'hF0, 64'h3C, 64'h30, 1, 0);
    wait_out("and_stall", lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_result", result_out, 64'h30);
      chk("stall_in_ready", X'(in_ready), '0);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_idle_valid", X'(out_valid), '0);
    chk("release_idle_ready", X'(in_ready), X'(1));
    // Flush blocks acceptance even when idle
    @(posedge clk); #1;
    flush = 1; in_valid = 1; fc = 4'd0; ic = 4'd0; src1 = 64'd1; src2 = 64'd1;
    @(negedge clk);
    chk("flush_in_ready", X'(in_ready), '0);
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_no_valid", X'(out_valid), '0);
    // Flush an in-flight divide
    send("div_flush", 4'd3, 4'd1, 64'd1000, 64'd3, 64'd0, 0, 1);
    repeat (19) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_valid", X'(out_valid), '0);
    chk("flush_ready", X'(in_ready), X'(1));
    run("sltu_after_flush", 4'd2, 4'd1, 64'd3, 64'd5, 64'd1, 1);
    // Reset an in-flight divide
    send("div_rst", 4'd3, 4'd1, 64'd1000, 64'd3, 64'd0, 0, 1);
    repeat (19) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_valid", X'(out_valid), '0);
    chk("midrst_result", result_out, '0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_ready", X'(in_ready), X'(1));
    run("sltu_after_rst", 4'd2, 4'd1, 64'd3, 64'd5, 64'd1, 1);
    repeat (80) @(posedge clk);
    chk("scoreboard_empty", X'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
